// File: rtl/dac_pkg.sv
// Shared types and default constants for the DAC voltage driver slice.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    CALC     = 2'd2,
    WAIT_UPD = 2'd3
  } state_t;

  localparam int VREF_MV_DEF  = 5000;
  localparam int MID_CODE_DEF = 128;
  localparam int Q_MAX_DEF    = 127;
  localparam int DIV_W_DEF    = 24;

  // Phase of the sys_clk/4 divider on which da_clk falls and a new code lands.
  localparam logic [1:0] PH_UPD = 2'd3;

endpackage

// File: rtl/dac_volt_driver_if.sv
// Setpoint request channel: sign/magnitude millivolts with a valid/ready handshake.
interface dac_volt_driver_if;
  logic [15:0] volt;
  logic        sign;
  logic        volt_valid;
  logic        volt_ready;

  modport master (output volt, output sign, output volt_valid, input volt_ready);
  modport slave  (input volt, input sign, input volt_valid, output volt_ready);
endinterface

// File: rtl/div_restoring.sv
// Unsigned restoring divider: one quotient bit per cycle, quotient valid W cycles after start.
// The first step is taken on the start edge itself, so done pulses in the W-th cycle after start.
// W must be at least 2.
module div_restoring #(
  parameter int W = 24
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [W-1:0]  step_rem_in, step_quo_in, step_dvs, step_rem_out, step_quo_out;
  logic [W:0]    trial;

  // One shift/compare/subtract step, fed from fresh operands on start or from the running state.
  always_comb begin
    step_rem_in = start ? '0 : rem_q;
    step_quo_in = start ? dividend : quo_q;
    step_dvs    = start ? divisor : dvs_q;
    trial       = {step_rem_in, step_quo_in[W-1]};
    if (trial >= {1'b0, step_dvs}) begin
      step_rem_out = W'(trial - {1'b0, step_dvs});
      step_quo_out = {step_quo_in[W-2:0], 1'b1};
    end else begin
      step_rem_out = trial[W-1:0];
      step_quo_out = {step_quo_in[W-2:0], 1'b0};
    end
  end

  // Sequencing: a start always (re)loads, otherwise iterate until the bit counter runs out.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = step_rem_out;
      quo_d  = step_quo_out;
      dvs_d  = divisor;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem_out;
      quo_d = step_quo_out;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/dac_volt_driver.sv
// Converts a sign/magnitude mV setpoint into an offset-binary DAC code and presents it
// on a parallel DAC bus, changing da_data only as its own divided da_clk falls.
module dac_volt_driver
  import dac_pkg::*;
#(
  parameter int VREF_MV  = VREF_MV_DEF,
  parameter int MID_CODE = MID_CODE_DEF,
  parameter int Q_MAX    = Q_MAX_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  dac_volt_driver_if.slave   req,
  output logic [7:0]         da_data,
  output logic               da_clk,
  output logic               done,
  output logic               clip
);
  localparam logic [15:0] VREF16 = 16'(VREF_MV);

  state_t           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic             da_clk_q, da_clk_d;
  logic [15:0]      volt_q, volt_d;
  logic             sign_q, sign_d;
  logic             clip_q, clip_d;
  logic [7:0]       pending_q, pending_d;
  logic [7:0]       da_data_q, da_data_d;
  logic             done_q, done_d;
  logic             upd;
  logic [15:0]      mag;
  logic [DIV_W-1:0] num;
  logic [DIV_W-1:0] quo;
  logic             div_done;
  logic [7:0]       code;
  logic             unused_quo_hi;

  // Free-running phase counter; da_clk is high for phases 2 and 3 and falls on the update edge.
  always_comb begin
    ph_d     = ph_q + 2'd1;
    da_clk_d = ph_d[1];
    upd      = (ph_q == PH_UPD);
  end

  // Saturate the magnitude and form the rounded numerator for the divider.
  always_comb begin
    mag  = (volt_q > VREF16) ? VREF16 : volt_q;
    num  = DIV_W'(mag) * DIV_W'(Q_MAX) + DIV_W'(VREF_MV / 2);
    code = sign_q ? (8'(MID_CODE) - quo[7:0]) : (8'(MID_CODE) + quo[7:0]);
  end

  // The quotient never exceeds Q_MAX, so only its low byte carries information.
  assign unused_quo_hi = ^quo[DIV_W-1:8];

  div_restoring #(.W(DIV_W)) u_div (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (state_q == LOAD),
    .dividend (num),
    .divisor  (DIV_W'(VREF_MV)),
    .quotient (quo),
    .done     (div_done)
  );

  // Conversion sequencer: accept, load the divider, wait for the quotient, then commit on upd.
  always_comb begin
    state_d   = state_q;
    volt_d    = volt_q;
    sign_d    = sign_q;
    clip_d    = clip_q;
    pending_d = pending_q;
    da_data_d = da_data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.volt_valid) begin
          volt_d  = req.volt;
          sign_d  = req.sign;
          state_d = LOAD;
        end
      end
      LOAD: begin
        clip_d  = (volt_q > VREF16);
        state_d = CALC;
      end
      CALC: begin
        if (div_done) begin
          pending_d = code;
          state_d   = WAIT_UPD;
        end
      end
      WAIT_UPD: begin
        if (upd) begin
          da_data_d = pending_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All control and output registers; reset aborts any conversion in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      ph_q      <= 2'd0;
      da_clk_q  <= 1'b0;
      volt_q    <= '0;
      sign_q    <= 1'b0;
      clip_q    <= 1'b0;
      pending_q <= 8'(MID_CODE);
      da_data_q <= 8'(MID_CODE);
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      da_clk_q  <= da_clk_d;
      volt_q    <= volt_d;
      sign_q    <= sign_d;
      clip_q    <= clip_d;
      pending_q <= pending_d;
      da_data_q <= da_data_d;
      done_q    <= done_d;
    end
  end

  assign req.volt_ready = (state_q == IDLE);
  assign da_data        = da_data_q;
  assign da_clk         = da_clk_q;
  assign done           = done_q;
  assign clip           = clip_q;

endmodule

// File: doc/dac_volt_driver.md
Name: dac_volt_driver

Overview:
- Output-side counterpart of the voltmeter ADC front-end.
- Accepts a signed millivolt setpoint in sign/magnitude form, the same format the ADC block produces on volt/sign.
- Converts the setpoint to an 8-bit offset-binary DAC code using a sequential divider.
- Drives the parallel DAC with its own divided data clock, updating the code only on a da_clk falling edge.

Parameters:
- VREF_MV, 5000: full-scale magnitude in mV; legal range 2..65535.
- MID_CODE, 128: DAC code for 0 mV.
- Q_MAX, 127: code step at full scale. MID_CODE+Q_MAX must be ≤255 and MID_CODE-Q_MAX must be ≥0.
- DIV_W, 24: numerator/divider width in bits.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- volt  in  16  setpoint magnitude, mV.
- sign  in  1  1 = negative.
- volt_valid  in  1  request strobe.
- volt_ready  out  1  high in IDLE.
- da_data  out  8  DAC code.
- da_clk  out  1  DAC latch clock, sys_clk/4.
- done  out  1  one-cycle pulse when da_data takes a new code.
- clip  out  1  last accepted request was saturated.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values:
  - da_data=MID_CODE, da_clk=0, done=0, clip=0, volt_ready=1.
  - State IDLE; internal 2-bit phase counter ph=0.
- Clock divider:
  - ph increments every cycle and wraps 3→0.
  - da_clk is registered: it is 1 while ph∈{2,3} and 0 otherwise, giving a period of 4 sys_clk and 50% duty.
  - Update strobe upd = (ph==3). On that edge da_clk falls and any committed code lands on da_data.
  - da_data is therefore stable for 2 sys_clk before each da_clk rising edge.
- FSM states: IDLE → LOAD → CALC → WAIT_UPD → IDLE.
- IDLE:
  - volt_ready=1.
  - On volt_valid=1, latch volt and sign, then go to LOAD. A handshake occurs in the same cycle.
- LOAD (1 cycle):
  - mag = min(volt, VREF_MV). clip <= (volt > VREF_MV); volt == VREF_MV is not a clip.
  - num = mag*Q_MAX + VREF_MV/2, rounding to nearest, unsigned DIV_W bits. Overflow is impossible because mag ≤ VREF_MV.
  - Start the divider: num / VREF_MV.
- CALC: wait exactly DIV_W cycles for the divider's done. Quotient q is in 0..Q_MAX.
- Code formation:
  - code = sign ? MID_CODE-q : MID_CODE+q.
  - If q==0 the code is MID_CODE regardless of sign.
  - Latch code as pending and go to WAIT_UPD.
- WAIT_UPD:
  - On the next upd cycle: da_data <= pending, done <= 1 for exactly one cycle, return to IDLE.
  - If upd is true in the cycle WAIT_UPD is entered, it commits immediately.
- Latency: accept → da_data change takes 1 + DIV_W + 1..4 cycles.
- volt_valid outside IDLE is ignored; there is no queueing.
- Reset mid-operation (any state) aborts the conversion: da_data returns to MID_CODE, no done is issued, and volt_ready=1 on the next cycle.
- da_data never changes except on an upd edge or on reset.
- clip holds its value until the next accepted request.

Decomposition:
- Shared package dac_pkg:
  - state enum (IDLE, LOAD, CALC, WAIT_UPD).
  - default constants VREF_MV_DEF, MID_CODE_DEF, Q_MAX_DEF.
  - phase constant PH_UPD=3.
- Sub-module div_restoring: parameter W, unsigned restoring divider, one bit per cycle, fixed W-cycle latency.
  - Ports: sys_clk, sys_rst, start, dividend[W], divisor[W], quotient[W], done.
  - start while busy restarts it.

Test Plan:
- Defaults; volt=2500, sign=0 → num=320000, q=64; da_data=192, clip=0, done is a single pulse aligned with a da_clk falling edge.
- volt=2500, sign=1 → da_data=64. volt=20, sign=0 → q=1, da_data=129. volt=1, sign=1 → da_data=128.
- volt=6000, sign=0 → da_data=255, clip=1. Then volt=6000, sign=1 → da_data=1. Then volt=5000 → clip=0, da_data=255.
- volt_valid held high continuously → one accept per conversion. volt_ready=0 from LOAD through WAIT_UPD, and the inputs applied while busy are ignored.
- Accept on each phase ph=0..3 → latency is DIV_W+2..DIV_W+5 cycles. da_data changes only when ph goes 3→0, with da_clk=1 for ph 2,3.
- sys_rst pulsed mid-CALC → next cycle da_data=128, da_clk=0, volt_ready=1, no done. A following request for 2500 yields 192.
